// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared Tuse/Tnew constants, forward-select encodings, shadow
//                slot type and hazard helper functions for stall_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef struct packed {
        logic [4:0] a;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       md;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic logic hazard_hit(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] a, input logic [1:0] tnew);
        return (src != 5'd0) && (src == a) && (tuse < tnew);
    endfunction

    // Nearest producer wins; a producer that is not ready yet blocks older ones.
    function automatic logic [1:0] fwd_pick(input logic [4:0] src,
                                            input logic [4:0] e_a, input logic [1:0] e_tnew,
                                            input logic use_e,
                                            input logic [4:0] m_a, input logic [1:0] m_tnew,
                                            input logic [4:0] w_a);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (src != 5'd0) begin
            if (use_e && (e_a == src))
                sel = (e_tnew == TNEW_0) ? FWD_E : FWD_NONE;
            else if (m_a == src)
                sel = (m_tnew == TNEW_0) ? FWD_M : FWD_NONE;
            else if (w_a == src)
                sel = FWD_W;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_busy_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_cnt
//  Description : Loadable saturating down-counter tracking HI/LO occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_cnt
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mult,
    input  logic start_div,
    input  logic cancel,
    output logic busy
);

    localparam int c_max   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_width = $clog2(c_max + 1);

    logic [c_width-1:0] r_cnt;

    // Cancel outranks a load: a flushed op never reaches the HI/LO unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (cancel)
            r_cnt <= '0;
        else if (start_mult)
            r_cnt <= c_width'(MULT_CYCLES);
        else if (start_div)
            r_cnt <= c_width'(DIV_CYCLES);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - c_width'(1);
    end

    assign busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : stall_unit
//  Description : D-stage stall and D/E forwarding control from a shadow
//                E/M/W scoreboard plus HI/LO busy tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module stall_unit
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_j,
    input  logic       d_r,
    input  logic       d_i,
    input  logic       d_ld,
    input  logic       d_st,
    input  logic       d_jal,
    input  logic       d_mfc0,
    input  logic       d_mult,
    input  logic       d_div,
    input  logic       d_hilo,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_rd,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       md_busy
);

    slot_t      r_e, r_m, r_w;
    slot_t      w_d, w_m_next, w_w_next;
    logic [1:0] w_tuse_rs, w_tuse_rt;
    logic       w_hz_stall, w_md_stall, w_md_busy;
    logic       w_issue;
    logic       w_unused;

    always_comb begin
        w_tuse_rs = TUSE_NONE;
        if (d_j)
            w_tuse_rs = TUSE_0;
        else if (d_r | d_i | d_ld | d_st)
            w_tuse_rs = TUSE_1;

        w_tuse_rt = TUSE_NONE;
        if (d_j)
            w_tuse_rt = TUSE_0;
        else if (d_r)
            w_tuse_rt = TUSE_1;
        else if (d_st)
            w_tuse_rt = TUSE_2;

        w_d = SLOT_EMPTY;
        if (d_r | d_jal)
            w_d.a = d_rd;
        else if (d_i | d_ld | d_mfc0)
            w_d.a = d_rt;

        if (d_jal)
            w_d.tnew = TNEW_0;
        else if (d_ld | d_mfc0)
            w_d.tnew = TNEW_2;
        else if (d_r | d_i)
            w_d.tnew = TNEW_1;

        w_d.rs = d_rs;
        w_d.rt = d_rt;
        w_d.md = d_mult | d_div;
    end

    always_comb begin
        w_m_next      = r_e;
        w_m_next.tnew = (r_e.tnew == TNEW_0) ? TNEW_0 : (r_e.tnew - 2'd1);
        w_w_next      = r_m;
        w_w_next.tnew = TNEW_0;
    end

    assign w_hz_stall = hazard_hit(d_rs, w_tuse_rs, r_e.a, r_e.tnew)
                      | hazard_hit(d_rs, w_tuse_rs, r_m.a, r_m.tnew)
                      | hazard_hit(d_rt, w_tuse_rt, r_e.a, r_e.tnew)
                      | hazard_hit(d_rt, w_tuse_rt, r_m.a, r_m.tnew);

    assign w_md_stall = (d_mult | d_div | d_hilo) & w_md_busy;
    assign stall      = w_hz_stall | w_md_stall;
    assign w_issue    = ~stall & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e <= SLOT_EMPTY;
            r_m <= SLOT_EMPTY;
            r_w <= SLOT_EMPTY;
        end else if (flush) begin
            r_e <= SLOT_EMPTY;
            r_m <= SLOT_EMPTY;
            r_w <= SLOT_EMPTY;
        end else begin
            r_e <= stall ? SLOT_EMPTY : w_d;
            r_m <= w_m_next;
            r_w <= w_w_next;
        end
    end

    assign fwd_rs_d = fwd_pick(d_rs, r_e.a, r_e.tnew, 1'b1, r_m.a, r_m.tnew, r_w.a);
    assign fwd_rt_d = fwd_pick(d_rt, r_e.a, r_e.tnew, 1'b1, r_m.a, r_m.tnew, r_w.a);
    assign fwd_rs_e = fwd_pick(r_e.rs, r_e.a, r_e.tnew, 1'b0, r_m.a, r_m.tnew, r_w.a);
    assign fwd_rt_e = fwd_pick(r_e.rt, r_e.a, r_e.tnew, 1'b0, r_m.a, r_m.tnew, r_w.a);

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_cnt (
        .clk        (clk),
        .reset      (reset),
        .start_mult (d_mult & w_issue),
        .start_div  (d_div & w_issue),
        .cancel     (flush & r_e.md),
        .busy       (w_md_busy)
    );

    assign md_busy = w_md_busy;

    assign w_unused = ^{r_m.rs, r_m.rt, r_m.md, r_w.tnew, r_w.rs, r_w.rt, r_w.md};

endmodule
`default_nettype wire

// File: tb/tb_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stall_unit
//  Description : Directed and randomized checks of stall_unit against a
//                timestamp-based pipeline occupancy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_unit;

    localparam int K_NOP = 0, K_ADDU = 1, K_ADDIU = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
    localparam int K_JAL = 6, K_MFC0 = 7, K_MULT = 8, K_DIV = 9, K_MFHI = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       d_j = 0, d_r = 0, d_i = 0, d_ld = 0, d_st = 0, d_jal = 0, d_mfc0 = 0;
    logic       d_mult = 0, d_div = 0, d_hilo = 0, flush = 0;
    logic [4:0] d_rs = 0, d_rt = 0, d_rd = 0;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    always #5 clk = ~clk;

    stall_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .d_j(d_j), .d_r(d_r), .d_i(d_i), .d_ld(d_ld), .d_st(d_st), .d_jal(d_jal),
        .d_mfc0(d_mfc0), .d_mult(d_mult), .d_div(d_div), .d_hilo(d_hilo),
        .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .flush(flush),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .md_busy(md_busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: each issued instruction remembers the cycle it entered E; its stage
    // and remaining latency follow from elapsed cycles.
    typedef struct {
        int a;
        int tnew;
        int rs;
        int rt;
        int entry;
    } inst_t;

    inst_t q[$];
    int    cyc = 0;
    int    md_len = 0;
    int    md_start = 0;

    int cur_rs, cur_rt, cur_dest, cur_tnew, cur_turs, cur_turt, cur_mdlen;
    bit cur_mdreq;

    function automatic int m_fwd(int src, int kfirst);
        int res;
        bit done;
        res  = 0;
        done = 0;
        if (src != 0) begin
            for (int k = kfirst; k <= 2; k++)
                for (int i = 0; i < q.size(); i++)
                    if (!done && (cyc - q[i].entry == k) && q[i].a == src) begin
                        res  = (k >= q[i].tnew) ? k + 1 : 0;
                        done = 1;
                    end
        end
        return res;
    endfunction

    function automatic int m_fwd_e(bit use_rt);
        int res;
        res = 0;
        for (int i = 0; i < q.size(); i++)
            if (cyc - q[i].entry == 0)
                res = m_fwd(use_rt ? q[i].rt : q[i].rs, 1);
        return res;
    endfunction

    function automatic bit m_busy();
        return (md_len > 0) && ((cyc - md_start) < md_len);
    endfunction

    function automatic bit m_stall();
        bit s;
        int k, left;
        s = 0;
        for (int i = 0; i < q.size(); i++) begin
            k = cyc - q[i].entry;
            if (k <= 1) begin
                left = q[i].tnew - k;
                if (left < 0) left = 0;
                if (cur_rs != 0 && q[i].a == cur_rs && cur_turs < left) s = 1;
                if (cur_rt != 0 && q[i].a == cur_rt && cur_turt < left) s = 1;
            end
        end
        if (cur_mdreq && m_busy()) s = 1;
        return s;
    endfunction

    task automatic drive(input int kind, input int rs, input int rt, input int rd, input bit fl);
        {d_j, d_r, d_i, d_ld, d_st, d_jal, d_mfc0, d_mult, d_div, d_hilo} = '0;
        d_rs = rs[4:0];
        d_rt = rt[4:0];
        d_rd = rd[4:0];
        flush = fl;
        cur_rs = rs; cur_rt = rt; cur_dest = 0; cur_tnew = 0;
        cur_turs = 3; cur_turt = 3; cur_mdlen = 0; cur_mdreq = 0;
        case (kind)
            K_ADDU:  begin d_r = 1; cur_dest = rd; cur_tnew = 1; cur_turs = 1; cur_turt = 1; end
            K_ADDIU: begin d_i = 1; cur_dest = rt; cur_tnew = 1; cur_turs = 1; end
            K_LW:    begin d_ld = 1; cur_dest = rt; cur_tnew = 2; cur_turs = 1; end
            K_SW:    begin d_st = 1; cur_turs = 1; cur_turt = 2; end
            K_BEQ:   begin d_j = 1; cur_turs = 0; cur_turt = 0; end
            K_JAL:   begin d_jal = 1; cur_dest = rd; cur_tnew = 0; end
            K_MFC0:  begin d_mfc0 = 1; cur_dest = rt; cur_tnew = 2; end
            K_MULT:  begin d_mult = 1; cur_mdlen = 5; cur_mdreq = 1; end
            K_DIV:   begin d_div = 1; cur_mdlen = 10; cur_mdreq = 1; end
            K_MFHI:  begin d_hilo = 1; d_r = 1; cur_dest = rd; cur_tnew = 1;
                           cur_turs = 1; cur_turt = 1; cur_mdreq = 1; end
            default: ;
        endcase
        #1;
    endtask

    task automatic advance();
        bit    s;
        inst_t n;
        s = m_stall();
        if (flush) begin
            if (md_len > 0 && cyc == md_start) md_len = 0;
            q.delete();
        end else begin
            for (int i = q.size() - 1; i >= 0; i--)
                if (cyc - q[i].entry >= 2) q.delete(i);
            if (!s) begin
                n.a = cur_dest; n.tnew = cur_tnew; n.rs = cur_rs; n.rt = cur_rt; n.entry = cyc + 1;
                q.push_back(n);
                if (cur_mdlen > 0) begin
                    md_len   = cur_mdlen;
                    md_start = cyc + 1;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        q.delete();
        md_len = 0;
        @(posedge clk);
        #1;
        reset = 0;
        drive(K_NOP, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(K_ADDU, 1, 2, 3, 0);
        checks += 6;
        if (stall !== 1'b0)    begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
        if (fwd_rs_d !== 2'd0) begin errors++; $display("FAIL reset_fwd_rs_d got %0d want 0", fwd_rs_d); end
        if (fwd_rt_d !== 2'd0) begin errors++; $display("FAIL reset_fwd_rt_d got %0d want 0", fwd_rt_d); end
        if (fwd_rs_e !== 2'd0) begin errors++; $display("FAIL reset_fwd_rs_e got %0d want 0", fwd_rs_e); end
        if (fwd_rt_e !== 2'd0) begin errors++; $display("FAIL reset_fwd_rt_e got %0d want 0", fwd_rt_e); end
        if (md_busy !== 1'b0)  begin errors++; $display("FAIL reset_md_busy got %0b want 0", md_busy); end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(K_LW, 5, 1, 0, 0);
        advance();
        drive(K_ADDU, 1, 4, 6, 0);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL lw_stall1 got %0b want 1", stall); end
        advance();
        checks += 2;
        if (stall !== 1'b0)    begin errors++; $display("FAIL lw_stall2 got %0b want 0", stall); end
        if (fwd_rs_d !== 2'd0) begin errors++; $display("FAIL lw_fwd_rs_d got %0d want 0", fwd_rs_d); end
        advance();
        drive(K_NOP, 0, 0, 0, 0);
        checks++;
        if (fwd_rs_e !== 2'd3) begin errors++; $display("FAIL lw_fwd_rs_e got %0d want 3", fwd_rs_e); end
        advance();
    endtask

    task automatic test_branch();
        do_reset();
        drive(K_ADDU, 3, 4, 2, 0);
        advance();
        drive(K_BEQ, 2, 3, 0, 0);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL beq_stall1 got %0b want 1", stall); end
        advance();
        checks += 3;
        if (stall !== 1'b0)    begin errors++; $display("FAIL beq_stall2 got %0b want 0", stall); end
        if (fwd_rs_d !== 2'd2) begin errors++; $display("FAIL beq_fwd_rs_d got %0d want 2", fwd_rs_d); end
        if (fwd_rt_d !== 2'd0) begin errors++; $display("FAIL beq_fwd_rt_d got %0d want 0", fwd_rt_d); end
        advance();
    endtask

    task automatic test_zero_jal();
        do_reset();
        drive(K_ADDU, 1, 1, 0, 0);
        advance();
        drive(K_ADDU, 0, 0, 5, 0);
        checks += 3;
        if (stall !== 1'b0)    begin errors++; $display("FAIL zero_stall got %0b want 0", stall); end
        if (fwd_rs_d !== 2'd0) begin errors++; $display("FAIL zero_fwd_rs_d got %0d want 0", fwd_rs_d); end
        if (fwd_rt_d !== 2'd0) begin errors++; $display("FAIL zero_fwd_rt_d got %0d want 0", fwd_rt_d); end
        advance();
        drive(K_JAL, 0, 0, 31, 0);
        advance();
        drive(K_ADDU, 31, 0, 7, 0);
        checks += 2;
        if (fwd_rs_d !== 2'd1) begin errors++; $display("FAIL jal_fwd_rs_d got %0d want 1", fwd_rs_d); end
        if (stall !== 1'b0)    begin errors++; $display("FAIL jal_stall got %0b want 0", stall); end
        advance();
    endtask

    task automatic test_mult_mfhi();
        do_reset();
        drive(K_MULT, 1, 2, 0, 0);
        advance();
        drive(K_MFHI, 0, 0, 8, 0);
        for (int i = 0; i < 6; i++) begin
            checks += 2;
            if (stall !== (i < 5))   begin errors++; $display("FAIL mfhi_stall cyc%0d got %0b want %0b", i, stall, (i < 5)); end
            if (md_busy !== (i < 5)) begin errors++; $display("FAIL mfhi_busy cyc%0d got %0b want %0b", i, md_busy, (i < 5)); end
            advance();
        end
    endtask

    task automatic test_flush_div();
        do_reset();
        drive(K_DIV, 1, 2, 0, 0);
        advance();
        drive(K_NOP, 0, 0, 0, 1);
        checks++;
        if (md_busy !== 1'b1) begin errors++; $display("FAIL div_busy got %0b want 1", md_busy); end
        advance();
        drive(K_MFHI, 0, 0, 8, 0);
        checks += 4;
        if (md_busy !== 1'b0)  begin errors++; $display("FAIL flush_busy got %0b want 0", md_busy); end
        if (stall !== 1'b0)    begin errors++; $display("FAIL flush_stall got %0b want 0", stall); end
        if (fwd_rs_e !== 2'd0) begin errors++; $display("FAIL flush_fwd_rs_e got %0d want 0", fwd_rs_e); end
        if (fwd_rt_e !== 2'd0) begin errors++; $display("FAIL flush_fwd_rt_e got %0d want 0", fwd_rt_e); end
        advance();
        checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL flush_busy2 got %0b want 0", md_busy); end
    endtask

    task automatic test_random();
        logic [1:0] e_rsd, e_rtd, e_rse, e_rte;
        bit         e_st, e_busy;
        int         kind, rd;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 10);
            rd   = (kind == K_JAL) ? 31 : pick_reg();
            drive(kind, pick_reg(), pick_reg(), rd, ($urandom_range(0, 15) == 0));
            e_st   = m_stall();
            e_busy = m_busy();
            e_rsd  = 2'(m_fwd(cur_rs, 0));
            e_rtd  = 2'(m_fwd(cur_rt, 0));
            e_rse  = 2'(m_fwd_e(0));
            e_rte  = 2'(m_fwd_e(1));
            checks += 6;
            if (stall !== e_st)      begin errors++; $display("FAIL rnd_stall n=%0d got %0b want %0b", n, stall, e_st); end
            if (md_busy !== e_busy)  begin errors++; $display("FAIL rnd_busy n=%0d got %0b want %0b", n, md_busy, e_busy); end
            if (fwd_rs_d !== e_rsd)  begin errors++; $display("FAIL rnd_fwd_rs_d n=%0d got %0d want %0d", n, fwd_rs_d, e_rsd); end
            if (fwd_rt_d !== e_rtd)  begin errors++; $display("FAIL rnd_fwd_rt_d n=%0d got %0d want %0d", n, fwd_rt_d, e_rtd); end
            if (fwd_rs_e !== e_rse)  begin errors++; $display("FAIL rnd_fwd_rs_e n=%0d got %0d want %0d", n, fwd_rs_e, e_rse); end
            if (fwd_rt_e !== e_rte)  begin errors++; $display("FAIL rnd_fwd_rt_e n=%0d got %0d want %0d", n, fwd_rt_e, e_rte); end
            advance();
        end
    endtask

    function automatic int pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 31 : r;
    endfunction

    task automatic test_reset_mid();
        do_reset();
        drive(K_DIV, 1, 2, 0, 0);
        advance();
        drive(K_LW, 0, 1, 0, 0);
        advance();
        drive(K_ADDU, 1, 3, 9, 0);
        checks += 2;
        if (stall !== 1'b1)   begin errors++; $display("FAIL mid_pre_stall got %0b want 1", stall); end
        if (md_busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy got %0b want 1", md_busy); end
        #1 reset = 1;
        q.delete();
        md_len = 0;
        #1;
        checks += 3;
        if (stall !== 1'b0)    begin errors++; $display("FAIL mid_rst_stall got %0b want 0", stall); end
        if (md_busy !== 1'b0)  begin errors++; $display("FAIL mid_rst_busy got %0b want 0", md_busy); end
        if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e} !== 8'd0)
            begin errors++; $display("FAIL mid_rst_fwd got %0h want 0", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}); end
        @(posedge clk);
        #1 reset = 0;
        #1;
        checks += 3;
        if (stall !== 1'b0)    begin errors++; $display("FAIL mid_rel_stall got %0b want 0", stall); end
        if (md_busy !== 1'b0)  begin errors++; $display("FAIL mid_rel_busy got %0b want 0", md_busy); end
        if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e} !== 8'd0)
            begin errors++; $display("FAIL mid_rel_fwd got %0h want 0", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}); end
        advance();
        checks += 3;
        if (stall !== 1'b0)    begin errors++; $display("FAIL mid_post_stall got %0b want 0", stall); end
        if (md_busy !== 1'b0)  begin errors++; $display("FAIL mid_post_busy got %0b want 0", md_busy); end
        if (fwd_rs_e !== 2'd0) begin errors++; $display("FAIL mid_post_fwd_rs_e got %0d want 0", fwd_rs_e); end
    endtask

    initial begin
        #2;
        test_reset();
        test_load_use();
        test_branch();
        test_zero_jal();
        test_mult_mfhi();
        test_flush_div();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
